rx_module: RTL and testbench
============================

Name: rx_module

Overview:
UART receive block, the line-side counterpart of the team's UART transmitter.
- Recovers frames from uart_rx_i using the shared 16x oversampling baud enable.
- Frame config uses the same 5-bit format as the transmitter.
- Presents the received byte with a one-cycle valid strobe and parity and framing error flags to the register/host side.

Parameters:
- MAX_DATA_WIDTH, 8, width of the data output register.
- DATA_COUNTER_WIDTH, 3, width of the data bit index.
- STOP_CONF_WIDTH, 2, width of the stop-bit counter and config field.
- SAMPLE_COUNTER_WIDTH, 4, oversample counter width; 16 ticks per bit.
- LINE_IDLE, 1'b0, line level for idle and stop bits; start bit is ~LINE_IDLE.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous reset, active low.
- baud_en_i  in  1  16x baud tick; all FSM and counter updates are qualified by it.
- rx_en_i  in  1  receiver enable.
- rx_conf_i  in  5  {data_size[1:0], stop_size[1:0], parity_en}.
- uart_rx_i  in  1  serial line, asynchronous.
- rx_data_o  out  8  last received word, LSB first on the line, unused upper bits 0.
- rx_valid_o  out  1  one-clk pulse when a frame completes.
- rx_parity_err_o  out  1  parity result of the last frame.
- rx_frame_err_o  out  1  a stop bit was not LINE_IDLE in the last frame.
- rx_busy_o  out  1  a frame is in progress.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: all outputs 0. FSM goes to Idle. Counters are 0. Synchronizer flops are preset to LINE_IDLE.
- Input: uart_rx_i passes through a 2-flop synchronizer (rx_s) before any use.
- Config: latched on the start-edge tick.
  - Data bits = 5 + data_size (5..8).
  - Stop bits = stop_size + 1 (1..4).
  - Parity: even, parity bit = XOR of the received data bits.
- FSM transitions occur on baud_en_i ticks only.
  - Idle: rx_en_i=1 and rx_s=~LINE_IDLE → StartChk; clear sample counter, latch config.
  - StartChk: at sample count 7, rx_s still ~LINE_IDLE → Data and reset counter. Otherwise (false start) → Idle with no flags.
  - Data: sample at count 7 into bit[data_idx]. When data_idx = last, go to Parity if parity_en, else Stop.
  - Parity: sample at count 7 and compare → Stop.
  - Stop: sample each stop bit at count 7; any bit ≠ LINE_IDLE sets the frame error. After the mid-sample of the last stop bit → Done.
  - Done: on the next clk (not tick-qualified), rx_valid_o=1 and outputs update → Idle. Ending at mid-stop allows back-to-back frames.
- Sample counter: after StartChk, increments 0..15 and wraps each bit. Bit periods are aligned so count 7 is mid-bit.
- Outputs:
  - rx_data_o, rx_parity_err_o and rx_frame_err_o update only with the rx_valid_o pulse and hold until the next completed frame.
  - A frame with an error still produces rx_valid_o.
- rx_busy_o is 1 in StartChk, Data, Parity and Stop.
- rx_en_i deasserted mid-frame: on the next tick, abort to Idle, no valid, outputs unchanged.
- rx_conf_i changes mid-frame are ignored until the next start edge.
- Reset mid-frame: immediate return to the reset state; the partial frame is discarded.

Optional Feature:
- Macro RX_MAJORITY_VOTE_EN.
  - Defined: each bit value is the majority of rx_s at counts 7, 8 and 9. Decision and state advance occur at count 9. The start check also uses the vote.
  - Undefined: single sample at count 7.
- Frame timing and outputs are otherwise identical in both builds.

Decomposition:
- Shared package uart_pkg:
  - FSM state encodings.
  - SampleCounterMax (15), SampleMid (7).
  - Base data bits (5).
  - Conf field bit positions, shared with the transmitter.
- One natural sub-module: sync_2ff, a 2-flop synchronizer with a reset value parameter, reusable elsewhere.

Test Plan:
- Conf 5'b11000 (8 data, 1 stop, no parity), frame 0xA5 → one rx_valid_o, rx_data_o=0xA5, both error flags 0, rx_busy_o low afterwards.
- Conf 5'b00011 (5 data, 2 stop, parity), data 5'b10110 with correct parity 1 → rx_data_o=0x16, parity_err 0. Repeat with parity bit 0 → parity_err 1.
- 8N1 frame 0x3C with the stop bit driven to ~LINE_IDLE → rx_valid_o, rx_data_o=0x3C, frame_err 1.
- Start-level glitch lasting 4 ticks → no rx_valid_o, FSM back in Idle, rx_busy_o pulses then clears.
- Two back-to-back 8N1 frames 0x55 then 0xFF with no idle gap → two valid pulses carrying the correct data. Next, drop rx_en_i mid-way through a third frame → no third pulse.
- Assert rstn_i low mid-frame, then release and send 0x81 → reset values observed, then rx_data_o=0x81. With RX_MAJORITY_VOTE_EN defined, a 1-tick inverted glitch at count 7 of each data bit → data still correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and
// the 5-bit frame config layout common to transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_CHK = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_DONE      = 3'd5
  } rx_state_e;

  localparam int SAMPLE_COUNTER_MAX = 15;
  localparam int SAMPLE_MID         = 7;
  localparam int BASE_DATA_BITS     = 5;

  // conf = {data_size[1:0], stop_size[1:0], parity_en}
  localparam int CONF_WIDTH         = 5;
  localparam int CONF_PARITY_EN_POS = 0;
  localparam int CONF_STOP_SIZE_LSB = 1;
  localparam int CONF_DATA_SIZE_LSB = 3;
  localparam int CONF_DATA_SIZE_W   = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops are
// preset to RESET_VAL so the output is quiet coming out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta <= RESET_VAL;
      q_o  <= RESET_VAL;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/rx_module.sv
// UART receiver using a 16x oversampling baud enable; optional 3-sample
// majority vote per bit when RX_MAJORITY_VOTE_EN is defined.
//
// state        | meaning
// ST_IDLE      | waiting for a start level on the line
// ST_START_CHK | confirming the start bit at mid-bit
// ST_DATA      | sampling data bits, LSB first
// ST_PARITY    | sampling the even-parity bit
// ST_STOP      | sampling stop bits
// ST_DONE      | one clk: publish word and flags
module rx_module
  import uart_pkg::*;
#(
  parameter int   MAX_DATA_WIDTH       = 8,
  parameter int   DATA_COUNTER_WIDTH   = 3,
  parameter int   STOP_CONF_WIDTH      = 2,
  parameter int   SAMPLE_COUNTER_WIDTH = 4,
  parameter logic LINE_IDLE            = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      baud_en_i,
  input  logic                      rx_en_i,
  input  logic [CONF_WIDTH-1:0]     rx_conf_i,
  input  logic                      uart_rx_i,
  output logic [MAX_DATA_WIDTH-1:0] rx_data_o,
  output logic                      rx_valid_o,
  output logic                      rx_parity_err_o,
  output logic                      rx_frame_err_o,
  output logic                      rx_busy_o
);

  localparam logic START_LVL = ~LINE_IDLE;
  localparam logic [SAMPLE_COUNTER_WIDTH-1:0] CNT_MAX = SAMPLE_COUNTER_WIDTH'(SAMPLE_COUNTER_MAX);
  localparam logic [SAMPLE_COUNTER_WIDTH-1:0] CNT_MID = SAMPLE_COUNTER_WIDTH'(SAMPLE_MID);

  rx_state_e state, state_nxt;

  logic                            rx_s;
  logic [SAMPLE_COUNTER_WIDTH-1:0] sample_cnt;
  logic [DATA_COUNTER_WIDTH-1:0]   data_idx;
  logic [DATA_COUNTER_WIDTH-1:0]   data_last;
  logic [DATA_COUNTER_WIDTH-1:0]   data_last_nxt;
  logic [STOP_CONF_WIDTH-1:0]      stop_idx;
  logic [STOP_CONF_WIDTH-1:0]      stop_last;
  logic                            parity_en_q;
  logic [MAX_DATA_WIDTH-1:0]       data_shift;
  logic                            parity_err_q;
  logic                            frame_err_q;
  logic                            sample_point;
  logic                            bit_val;
  logic                            start_seen;

  sync_2ff #(
    .RESET_VAL(LINE_IDLE)
  ) u_sync_rx (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .d_i   (uart_rx_i),
    .q_o   (rx_s)
  );

`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [SAMPLE_COUNTER_WIDTH-1:0] CNT_VOTE2 = CNT_MID + 1'b1;
  localparam logic [SAMPLE_COUNTER_WIDTH-1:0] CNT_VOTE3 = CNT_MID + 2'd2;

  logic vote_a, vote_b;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vote_a <= LINE_IDLE;
      vote_b <= LINE_IDLE;
    end else if (baud_en_i && rx_busy_o) begin
      if (sample_cnt == CNT_MID)   vote_a <= rx_s;
      if (sample_cnt == CNT_VOTE2) vote_b <= rx_s;
    end
  end

  assign sample_point = (sample_cnt == CNT_VOTE3);
  assign bit_val      = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
  assign sample_point = (sample_cnt == CNT_MID);
  assign bit_val      = rx_s;
`endif

  assign rx_busy_o  = (state == ST_START_CHK) || (state == ST_DATA) ||
                      (state == ST_PARITY)    || (state == ST_STOP);
  assign start_seen = baud_en_i && rx_en_i && (rx_s == START_LVL);
  assign data_last_nxt = DATA_COUNTER_WIDTH'(BASE_DATA_BITS - 1) +
                         DATA_COUNTER_WIDTH'(rx_conf_i[CONF_DATA_SIZE_LSB +: CONF_DATA_SIZE_W]);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_seen) state_nxt = ST_START_CHK;
      end
      ST_START_CHK: begin
        if (baud_en_i) begin
          if (!rx_en_i)          state_nxt = ST_IDLE;
          else if (sample_point) state_nxt = (bit_val == START_LVL) ? ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        if (baud_en_i) begin
          if (!rx_en_i) state_nxt = ST_IDLE;
          else if (sample_point && data_idx == data_last)
            state_nxt = parity_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (baud_en_i) begin
          if (!rx_en_i)          state_nxt = ST_IDLE;
          else if (sample_point) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_en_i) begin
          if (!rx_en_i) state_nxt = ST_IDLE;
          else if (sample_point && stop_idx == stop_last) state_nxt = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Counter keeps running through the start check so count 7 stays mid-bit.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sample_cnt   <= '0;
      data_idx     <= '0;
      data_last    <= '0;
      stop_idx     <= '0;
      stop_last    <= '0;
      parity_en_q  <= 1'b0;
      data_shift   <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else if (baud_en_i) begin
      if (state == ST_IDLE) begin
        if (start_seen) begin
          sample_cnt   <= '0;
          data_idx     <= '0;
          stop_idx     <= '0;
          data_last    <= data_last_nxt;
          stop_last    <= rx_conf_i[CONF_STOP_SIZE_LSB +: STOP_CONF_WIDTH];
          parity_en_q  <= rx_conf_i[CONF_PARITY_EN_POS];
          data_shift   <= '0;
          parity_err_q <= 1'b0;
          frame_err_q  <= 1'b0;
        end
      end else if (rx_busy_o) begin
        sample_cnt <= (sample_cnt == CNT_MAX) ? '0 : sample_cnt + 1'b1;
        if (sample_point) begin
          case (state)
            ST_DATA: begin
              data_shift[data_idx] <= bit_val;
              data_idx             <= data_idx + 1'b1;
            end
            ST_PARITY: parity_err_q <= (bit_val != ^data_shift);
            ST_STOP: begin
              if (bit_val != LINE_IDLE) frame_err_q <= 1'b1;
              stop_idx <= stop_idx + 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_data_o       <= '0;
      rx_valid_o      <= 1'b0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      if (state == ST_DONE) begin
        rx_valid_o      <= 1'b1;
        rx_data_o       <= data_shift;
        rx_parity_err_o <= parity_err_q;
        rx_frame_err_o  <= frame_err_q;
      end
    end
  end

endmodule

// File: tb/tb_rx_module.sv
// Randomized scoreboard bench for rx_module: frames are driven on the line,
// the expected word and flags are queued, and a monitor checks each valid.
module tb_rx_module;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       baud_en_i = 1'b0;
  logic       rx_en_i = 1'b0;
  logic [4:0] rx_conf_i = 5'b11000;
  logic       uart_rx_i = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_parity_err_o;
  logic       rx_frame_err_o;
  logic       rx_busy_o;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_data = 8'h00;

  rx_module dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .baud_en_i      (baud_en_i),
    .rx_en_i        (rx_en_i),
    .rx_conf_i      (rx_conf_i),
    .uart_rx_i      (uart_rx_i),
    .rx_data_o      (rx_data_o),
    .rx_valid_o     (rx_valid_o),
    .rx_parity_err_o(rx_parity_err_o),
    .rx_frame_err_o (rx_frame_err_o),
    .rx_busy_o      (rx_busy_o)
  );

  always #5 clk_i = ~clk_i;

  // one-clk baud tick every 4 clocks
  initial begin
    forever begin
      @(negedge clk_i) baud_en_i = 1'b1;
      @(negedge clk_i) baud_en_i = 1'b0;
      repeat (2) @(negedge clk_i);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rstn_i && rx_valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data %0h with no frame pending", rx_data_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rx_data", rx_data_o, e.data);
        check("parity_err", rx_parity_err_o, e.perr);
        check("frame_err", rx_frame_err_o, e.ferr);
      end
    end
  end

  task automatic wait_tick();
    do @(posedge clk_i); while (baud_en_i !== 1'b1);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      wait_tick();
      uart_rx_i = 1'b0;
    end
  endtask

  // one bit period; glitch inverts the line for the interval that the
  // receiver sees at its first mid-bit sample
  task automatic drive_bit(input logic v, input bit glitch);
    for (int t = 0; t < 16; t++) begin
      wait_tick();
      uart_rx_i = (glitch && t == 8) ? ~v : v;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic [4:0] conf,
                            input logic par_bit, input logic stop_bad,
                            input bit glitch, input int drop_at,
                            input bit scramble, input bit expect_it);
    int         nbits;
    int         nstop;
    logic [7:0] masked;
    exp_t       e;
    nbits  = 5 + int'(conf[4:3]);
    nstop  = 1 + int'(conf[2:1]);
    masked = data & 8'((1 << nbits) - 1);
    if (expect_it) begin
      e.data = masked;
      e.perr = conf[0] ? (par_bit != ^masked) : 1'b0;
      e.ferr = stop_bad;
      sb.push_back(e);
      last_data = masked;
    end
    rx_conf_i = conf;
    drive_bit(1'b1, 1'b0);
    if (scramble) rx_conf_i = 5'($urandom);
    for (int i = 0; i < nbits; i++) begin
      if (i == drop_at) rx_en_i = 1'b0;
      drive_bit(data[i], glitch);
    end
    if (conf[0]) drive_bit(par_bit, 1'b0);
    for (int s = 0; s < nstop; s++)
      drive_bit((stop_bad && s == nstop - 1) ? 1'b1 : 1'b0, 1'b0);
  endtask

  initial begin
    bit busy_seen;

    #1;
    check("reset_data", rx_data_o, 8'h00);
    check("reset_valid", rx_valid_o, 1'b0);
    check("reset_perr", rx_parity_err_o, 1'b0);
    check("reset_ferr", rx_frame_err_o, 1'b0);
    check("reset_busy", rx_busy_o, 1'b0);
    repeat (3) @(negedge clk_i);
    rstn_i  = 1'b1;
    rx_en_i = 1'b1;
    idle_ticks(4);

    send_frame(8'hA5, 5'b11000, 1'b0, 1'b0, 0, -1, 0, 1);
    idle_ticks(4);
    check("busy_after_a5", rx_busy_o, 1'b0);

    send_frame(8'h16, 5'b00011, 1'b1, 1'b0, 0, -1, 0, 1);
    idle_ticks(4);
    send_frame(8'h16, 5'b00011, 1'b0, 1'b0, 0, -1, 0, 1);
    idle_ticks(4);

    send_frame(8'h3C, 5'b11000, 1'b0, 1'b1, 0, -1, 0, 1);
    idle_ticks(24);

    busy_seen = 0;
    for (int t = 0; t < 20; t++) begin
      wait_tick();
      uart_rx_i = (t < 4) ? 1'b1 : 1'b0;
      if (rx_busy_o) busy_seen = 1;
    end
    check("glitch_busy_seen", busy_seen, 1'b1);
    check("glitch_busy_clear", rx_busy_o, 1'b0);
    check("glitch_data_held", rx_data_o, last_data);

    send_frame(8'h55, 5'b11000, 1'b0, 1'b0, 0, -1, 0, 1);
    send_frame(8'hFF, 5'b11000, 1'b0, 1'b0, 0, -1, 0, 1);
    send_frame(8'h12, 5'b11000, 1'b0, 1'b0, 0, 3, 0, 0);
    idle_ticks(20);
    check("abort_data_held", rx_data_o, 8'hFF);
    check("abort_busy", rx_busy_o, 1'b0);
    rx_en_i = 1'b1;
    idle_ticks(4);

    rx_conf_i = 5'b11000;
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    rstn_i = 1'b0;
    uart_rx_i = 1'b0;
    #1;
    check("midrst_data", rx_data_o, 8'h00);
    check("midrst_valid", rx_valid_o, 1'b0);
    check("midrst_perr", rx_parity_err_o, 1'b0);
    check("midrst_ferr", rx_frame_err_o, 1'b0);
    check("midrst_busy", rx_busy_o, 1'b0);
    repeat (5) @(negedge clk_i);
    rstn_i = 1'b1;
    idle_ticks(4);
    send_frame(8'h81, 5'b11000, 1'b0, 1'b0, 0, -1, 0, 1);
    idle_ticks(4);

`ifdef RX_MAJORITY_VOTE_EN
    send_frame(8'hC3, 5'b11000, 1'b0, 1'b0, 1, -1, 0, 1);
    idle_ticks(4);
`endif

    for (int n = 0; n < 10; n++) begin
      logic [4:0] conf;
      logic [7:0] data;
      logic       pbit;
      logic       sbad;
      conf = 5'($urandom);
      data = 8'($urandom);
      pbit = ($urandom_range(0, 1) == 1) ? ^(data & 8'((1 << (5 + int'(conf[4:3]))) - 1)) : ~^(data & 8'((1 << (5 + int'(conf[4:3]))) - 1));
      sbad = ($urandom_range(0, 3) == 0);
      send_frame(data, conf, pbit, sbad, 0, -1, 1, 1);
      idle_ticks(24);
    end

    idle_ticks(8);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
